mips_mc_cpu: RTL and testbench
==============================

Name: mips_mc_cpu

Overview:
Multi-cycle successor to the single-cycle MIPS core. It holds its own PC, instruction register and datapath latches, and runs each instruction through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memories are reached over req/ready handshakes with a bounded wait. The register file stays external, with combinational read and synchronous write on we3. A retired-instruction counter and halt/error status feed the test harness.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, maximum cycles a memory request may wait for ready before bus error
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc  out  32  current PC register
imem_req  out  1  instruction fetch request
imem_a  out  32  fetch address (= pc)
imem_ready  in  1  fetch data valid / accepted
imem_rd  in  32  fetched instruction
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load
dmem_a  out  32  data address
dmem_wd  out  32  store data
dmem_ready  in  1  data access complete
dmem_rd  in  32  load data
register_a1, register_a2, register_a3  out  5  register numbers
register_we3  out  1  register write enable
register_wd3  out  32  register write data
register_rd1, register_rd2  in  32  register read data
retired  out  CNT_W  instructions completed
halted  out  1  core stopped
bus_error  out  1  halt cause: memory timeout
illegal  out  1  halt cause: unsupported opcode/funct

Behaviour:
- Reset is asynchronous and active-low (rst_n). While rst_n=0: pc=RESET_PC, state=FETCH, IR=0, retired=0, and all of req, we, we3, halted, bus_error and illegal are 0.
- FETCH: imem_req=1, imem_a=pc. On the first edge with imem_ready=1, IR<=imem_rd and go to DECODE. Ready may arrive in the same cycle as req (zero wait).
- DECODE: a1=IR[25:21], a2=IR[20:16]. Latch A<=rd1 and B<=rd2. Decode opcode/funct. An unsupported code goes to HALT with illegal=1.
- Supported codes and ALU operations:
  - R-type: add, sub, and, or, slt, jr.
  - I-type: addi, lw, sw, beq, bne.
  - J-type: j, jal.
  - ALU codes: 3'b010 add, 110 sub, 000 and, 001 or, 111 slt (signed). Sign-extended 16-bit immediate.
- EXEC:
  - ALUOut<=result.
  - beq/bne: pc<=PC+4+(sext(imm)<<2) if taken, else PC+4. Retire, then FETCH.
  - j: pc<={pc4[31:28],IR[25:0],2'b00}. Retire, then FETCH.
  - jr: pc<=A. Retire, then FETCH.
  - jal: latch link=PC+4, pc<=target, then WB.
  - lw/sw: go to MEM.
  - R-type/addi: go to WB.
  - Every non-control instruction sets pc<=PC+4 here.
- MEM: dmem_req=1, dmem_a=ALUOut, dmem_wd=B, dmem_we=(sw). On ready:
  - sw: retire, then FETCH.
  - lw: MDR<=dmem_rd, then WB.
- WB: register_we3=1 for exactly one cycle.
  - a3 = rd (IR[15:11]) for R-type, rt for addi/lw, 5'd31 for jal.
  - wd3 = ALUOut / MDR / link respectively.
  - Retire, then FETCH.
- Latency with zero-wait memory: branch/j/jr 3 cycles, R/addi/sw/jal 4, lw 5. Each memory wait cycle adds 1.
- Handshake:
  - req stays high until ready is sampled high.
  - Address, we and wd stay stable while req is high.
  - ready is ignored while req is low.
- Timeout: a wait counter clears on state entry and increments each FETCH/MEM cycle without ready. Reaching TIMEOUT goes to HALT with bus_error=1, and the pending access is abandoned.
- HALT:
  - All req and we outputs are 0. halted=1.
  - pc holds the address of the faulting instruction.
  - Sticky until reset.
- Retired counter: increments once per completed instruction and wraps modulo 2^CNT_W.
- Register write ordering: the WB write lands at the edge ending WB, so the next DECODE reads the new value. No forwarding is needed.
- Writes to r0 are issued as normal. The external file ignores them.
- Reset asserted mid-access: the core drops req immediately (asynchronously), and the access is void.

Decomposition:
- Shared package: opcode/funct constants, ALU control codes, state encoding.
- One sub-module, mips_mc_alu: combinational 32-bit ALU with a zero flag, reused for the PC+4 and branch adders.
- The FSM and datapath registers stay in mips_mc_cpu.

Test Plan:
- Reset: hold rst_n=0 with RESET_PC=0x100 → pc=0x100, retired=0, no req. Release → imem_req=1, imem_a=0x100 next cycle.
- addi $1,$0,5 then add $2,$1,$1, zero-wait memory → WB writes a3=1/wd3=5, then a3=2/wd3=10. Each instruction takes 4 cycles; retired=2.
- sw $2,8($0) then lw $3,8($0) with 2 wait cycles on dmem → store seen with a=8, wd=10, we=1, and req held 3 cycles. Load writes $3=10; lw takes 7 cycles.
- beq taken (imm=-1) from pc=0x10 → pc=0x10 in 3 cycles. Same operands with bne → pc=0x14. jal from 0x20 → $31=0x24, pc=target.
- imem_ready held low, TIMEOUT=16 → after 16 waiting cycles halted=1, bus_error=1, imem_req=0, pc unchanged.
- Opcode 6'b111111 → halted=1, illegal=1, no register or memory write. Assert rst_n=0 → all flags clear.

Source files
------------

// File: rtl/mips_mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs, ALU codes, FSM states.
package mips_mc_cpu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // True for every opcode/funct pair the core can execute.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    logic legal;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_JR: legal = 1'b1;
          default:                                      legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Branches compare by subtraction; memory ops and addi compute addresses by addition.
  function automatic alu_op_e alu_sel(input logic [5:0] op, input logic [5:0] funct);
    alu_op_e sel;
    sel = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_SUB:  sel = ALU_SUB;
        FN_AND:  sel = ALU_AND;
        FN_OR:   sel = ALU_OR;
        FN_SLT:  sel = ALU_SLT;
        default: sel = ALU_ADD;
      endcase
    end else if (op == OP_BEQ || op == OP_BNE) begin
      sel = ALU_SUB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mips_mc_cpu_if.sv
// Memory, register-file and status bundle between the core (master) and its harness (slave).
interface mips_mc_cpu_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      pc;
  logic             imem_req;
  logic [31:0]      imem_a;
  logic             imem_ready;
  logic [31:0]      imem_rd;
  logic             dmem_req;
  logic             dmem_we;
  logic [31:0]      dmem_a;
  logic [31:0]      dmem_wd;
  logic             dmem_ready;
  logic [31:0]      dmem_rd;
  logic [4:0]       register_a1;
  logic [4:0]       register_a2;
  logic [4:0]       register_a3;
  logic             register_we3;
  logic [31:0]      register_wd3;
  logic [31:0]      register_rd1;
  logic [31:0]      register_rd2;
  logic [CNT_W-1:0] retired;
  logic             halted;
  logic             bus_error;
  logic             illegal;

  modport master (
    output pc, imem_req, imem_a, dmem_req, dmem_we, dmem_a, dmem_wd,
           register_a1, register_a2, register_a3, register_we3, register_wd3,
           retired, halted, bus_error, illegal,
    input  imem_ready, imem_rd, dmem_ready, dmem_rd, register_rd1, register_rd2
  );

  modport slave (
    input  pc, imem_req, imem_a, dmem_req, dmem_we, dmem_a, dmem_wd,
           register_a1, register_a2, register_a3, register_we3, register_wd3,
           retired, halted, bus_error, illegal,
    output imem_ready, imem_rd, dmem_ready, dmem_rd, register_rd1, register_rd2
  );
endinterface

// File: rtl/mips_mc_alu.sv
// Combinational 32-bit ALU with zero flag; also serves as the PC+4 and branch-target adder.
module mips_mc_alu
  import mips_mc_cpu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y_c,
  output logic            zero_c
);

  always_comb begin
    y_c = '0;
    case (op)
      ALU_AND: y_c = a & b;
      ALU_OR:  y_c = a | b;
      ALU_ADD: y_c = a + b;
      ALU_SUB: y_c = a - b;
      ALU_SLT: y_c = ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
      default: y_c = '0;
    endcase
  end

  assign zero_c = (y_c == '0);

endmodule

// File: rtl/mips_mc_cpu.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB sequencer with handshaked memories,
// external register file, retired counter and sticky halt status.
module mips_mc_cpu
  import mips_mc_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input logic           clk,
  input logic           rst_n,
  mips_mc_cpu_if.master bus
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d, pc_inst_q, pc_inst_d, ir_q, ir_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [31:0]       dmem_a_q, dmem_a_d, dmem_wd_q, dmem_wd_d;
  logic              we3_q, we3_d;
  logic [4:0]        a3_q, a3_d;
  logic [31:0]       wd3_q, wd3_d;
  logic              halted_q, halted_d, bus_error_q, bus_error_d, illegal_q, illegal_d;

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd;
  logic [31:0] sext_imm, br_off, alu_b, alu_y, pc4, br_tgt;
  logic        alu_zero, unused_pc4_zero, unused_br_zero;
  alu_op_e     alu_ctl;

  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign br_off   = {sext_imm[29:0], 2'b00};
  assign alu_b    = (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE) ? b_q : sext_imm;
  assign alu_ctl  = alu_sel(op, funct);

  mips_mc_alu u_alu (.a(a_q),  .b(alu_b),  .op(alu_ctl), .y_c(alu_y),  .zero_c(alu_zero));
  mips_mc_alu u_pc4 (.a(pc_q), .b(32'd4),  .op(ALU_ADD), .y_c(pc4),    .zero_c(unused_pc4_zero));
  mips_mc_alu u_br  (.a(pc4),  .b(br_off), .op(ALU_ADD), .y_c(br_tgt), .zero_c(unused_br_zero));

  // Next-state and next-output logic; every registered output is computed one edge ahead.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_inst_d   = pc_inst_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    wait_d      = '0;
    retired_d   = retired_q;
    imem_req_d  = imem_req_q;
    dmem_req_d  = dmem_req_q;
    dmem_we_d   = dmem_we_q;
    dmem_a_d    = dmem_a_q;
    dmem_wd_d   = dmem_wd_q;
    we3_d       = 1'b0;
    a3_d        = a3_q;
    wd3_d       = wd3_q;
    halted_d    = halted_q;
    bus_error_d = bus_error_q;
    illegal_d   = illegal_q;

    case (state_q)
      S_FETCH: begin
        // Request is raised one cycle after reset release, then held until accepted.
        if (!imem_req_q) begin
          imem_req_d = 1'b1;
        end else if (bus.imem_ready) begin
          ir_d       = bus.imem_rd;
          pc_inst_d  = pc_q;
          imem_req_d = 1'b0;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          imem_req_d  = 1'b0;
          halted_d    = 1'b1;
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        a_d = bus.register_rd1;
        b_d = bus.register_rd2;
        if (is_legal(op, funct)) begin
          state_d = S_EXEC;
        end else begin
          halted_d  = 1'b1;
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end

      S_EXEC: begin
        case (op)
          OP_BEQ, OP_BNE: begin
            pc_d       = ((op == OP_BEQ) == alu_zero) ? br_tgt : pc4;
            retired_d  = retired_q + CNT_W'(1);
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end
          OP_J: begin
            pc_d       = {pc4[31:28], ir_q[25:0], 2'b00};
            retired_d  = retired_q + CNT_W'(1);
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JAL: begin
            pc_d    = {pc4[31:28], ir_q[25:0], 2'b00};
            a3_d    = 5'd31;
            wd3_d   = pc4;
            we3_d   = 1'b1;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            pc_d       = pc4;
            dmem_req_d = 1'b1;
            dmem_we_d  = (op == OP_SW);
            dmem_a_d   = alu_y;
            dmem_wd_d  = b_q;
            state_d    = S_MEM;
          end
          OP_RTYPE: begin
            if (funct == FN_JR) begin
              pc_d       = a_q;
              retired_d  = retired_q + CNT_W'(1);
              imem_req_d = 1'b1;
              state_d    = S_FETCH;
            end else begin
              pc_d    = pc4;
              a3_d    = rd;
              wd3_d   = alu_y;
              we3_d   = 1'b1;
              state_d = S_WB;
            end
          end
          default: begin
            pc_d    = pc4;
            a3_d    = rt;
            wd3_d   = alu_y;
            we3_d   = 1'b1;
            state_d = S_WB;
          end
        endcase
      end

      S_MEM: begin
        if (bus.dmem_ready) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (dmem_we_q) begin
            retired_d  = retired_q + CNT_W'(1);
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end else begin
            a3_d    = rt;
            wd3_d   = bus.dmem_rd;
            we3_d   = 1'b1;
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Abandon the access and point pc back at the faulting load/store.
          pc_d        = pc_inst_q;
          dmem_req_d  = 1'b0;
          dmem_we_d   = 1'b0;
          halted_d    = 1'b1;
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        retired_d  = retired_q + CNT_W'(1);
        imem_req_d = 1'b1;
        state_d    = S_FETCH;
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      pc_inst_q   <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      wait_q      <= '0;
      retired_q   <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      dmem_a_q    <= '0;
      dmem_wd_q   <= '0;
      we3_q       <= 1'b0;
      a3_q        <= '0;
      wd3_q       <= '0;
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_inst_q   <= pc_inst_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      wait_q      <= wait_d;
      retired_q   <= retired_d;
      imem_req_q  <= imem_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_we_q   <= dmem_we_d;
      dmem_a_q    <= dmem_a_d;
      dmem_wd_q   <= dmem_wd_d;
      we3_q       <= we3_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
      halted_q    <= halted_d;
      bus_error_q <= bus_error_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.imem_req     = imem_req_q;
  assign bus.imem_a       = pc_q;
  assign bus.dmem_req     = dmem_req_q;
  assign bus.dmem_we      = dmem_we_q;
  assign bus.dmem_a       = dmem_a_q;
  assign bus.dmem_wd      = dmem_wd_q;
  assign bus.register_a1  = ir_q[25:21];
  assign bus.register_a2  = ir_q[20:16];
  assign bus.register_a3  = a3_q;
  assign bus.register_we3 = we3_q;
  assign bus.register_wd3 = wd3_q;
  assign bus.retired      = retired_q;
  assign bus.halted       = halted_q;
  assign bus.bus_error    = bus_error_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_mips_mc_cpu.sv
// Directed bench for mips_mc_cpu: harness memories and register file, hand-computed expectations.
module tb_mips_mc_cpu;

  localparam logic [31:0] ILL = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  mips_mc_cpu_if #(.CNT_W(32)) bus ();
  mips_mc_cpu #(.RESET_PC(32'h100), .TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  logic [31:0] regs [32];
  logic        imem_stall, dmem_stall;
  int          dmem_wait;
  int          dcnt, iwait_cycles, cyc;

  logic [31:0] fetch_addr [$];
  int          fetch_cyc [$];
  logic [4:0]  wb_a3 [$];
  logic [31:0] wb_wd3 [$];
  logic [31:0] acc_a [$];
  logic [31:0] acc_wd [$];
  logic        acc_we [$];
  int          acc_len [$];

  assign bus.imem_rd      = imem[bus.imem_a[9:2]];
  assign bus.imem_ready   = bus.imem_req && !imem_stall;
  assign bus.dmem_rd      = dmem[bus.dmem_a[7:2]];
  assign bus.dmem_ready   = bus.dmem_req && !dmem_stall && (dcnt >= dmem_wait);
  assign bus.register_rd1 = regs[bus.register_a1];
  assign bus.register_rd2 = regs[bus.register_a2];

  // Harness: data memory, register file and transaction logs.
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc <= 0;
      dcnt <= 0;
      iwait_cycles <= 0;
      fetch_addr.delete(); fetch_cyc.delete();
      wb_a3.delete(); wb_wd3.delete();
      acc_a.delete(); acc_wd.delete(); acc_we.delete(); acc_len.delete();
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
    end else begin
      cyc <= cyc + 1;
      if (bus.imem_req && bus.imem_ready) begin
        fetch_addr.push_back(bus.imem_a);
        fetch_cyc.push_back(cyc);
      end
      if (bus.imem_req && !bus.imem_ready) iwait_cycles <= iwait_cycles + 1;
      if (bus.dmem_req) begin
        if (bus.dmem_ready) begin
          acc_a.push_back(bus.dmem_a); acc_wd.push_back(bus.dmem_wd);
          acc_we.push_back(bus.dmem_we); acc_len.push_back(dcnt + 1);
          dcnt <= 0;
          if (bus.dmem_we) dmem[bus.dmem_a[7:2]] <= bus.dmem_wd;
        end else begin
          dcnt <= dcnt + 1;
        end
      end
      if (bus.register_we3) begin
        wb_a3.push_back(bus.register_a3);
        wb_wd3.push_back(bus.register_wd3);
        if (bus.register_a3 != 5'd0) regs[bus.register_a3] <= bus.register_wd3;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_stall = 1'b0;
    dmem_stall = 1'b0;
    dmem_wait = 0;
    for (int i = 0; i < 256; i++) imem[i] = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    imem[addr[9:2]] = w;
  endtask

  task automatic wait_halt(input int max, input string name);
    int n = 0;
    while (!bus.halted && n < max) begin @(negedge clk); n++; end
    vectors++;
    if (!bus.halted) begin miscompares++; $display("FAIL %s_halt: not halted after %0d cycles", name, max); end
  endtask

  task automatic wait_fetches(input int cnt, input int max, input string name);
    int n = 0;
    while (fetch_addr.size() < cnt && n < max) begin @(negedge clk); n++; end
    vectors++;
    if (fetch_addr.size() < cnt) begin miscompares++; $display("FAIL %s_fetches: got %0d want %0d", name, fetch_addr.size(), cnt); end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.pc !== 32'h100) begin miscompares++; $display("FAIL reset_pc: got %h want 00000100", bus.pc); end
    vectors++; if (bus.retired !== 32'd0) begin miscompares++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
    vectors++; if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.register_we3 !== 1'b0) begin
      miscompares++; $display("FAIL reset_req: imem_req=%b dmem_req=%b we=%b we3=%b want 0", bus.imem_req, bus.dmem_req, bus.dmem_we, bus.register_we3); end
    vectors++; if (bus.halted !== 1'b0 || bus.bus_error !== 1'b0 || bus.illegal !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: halted=%b bus_error=%b illegal=%b want 0", bus.halted, bus.bus_error, bus.illegal); end
    put(32'h100, ILL);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.imem_req !== 1'b1 || bus.imem_a !== 32'h100) begin
      miscompares++; $display("FAIL release_fetch: req=%b a=%h want 1/00000100", bus.imem_req, bus.imem_a); end
  endtask

  task automatic test_alu();
    logic [4:0]  ea [7];
    logic [31:0] ew [7];
    ea = '{5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
    ew = '{32'd5, 32'd10, 32'hFFFF_FFFD, 32'd1, 32'd8, 32'd5, 32'hFFFF_FFFD};
    do_reset();
    put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h104, enc_r(5'd1, 5'd1, 5'd2, 6'h20));
    put(32'h108, enc_i(6'h08, 5'd0, 5'd4, 16'hFFFD));
    put(32'h10C, enc_r(5'd4, 5'd1, 5'd5, 6'h2a));
    put(32'h110, enc_r(5'd1, 5'd4, 5'd6, 6'h22));
    put(32'h114, enc_r(5'd1, 5'd4, 5'd7, 6'h24));
    put(32'h118, enc_r(5'd1, 5'd4, 5'd8, 6'h25));
    put(32'h11C, ILL);
    rst_n = 1'b1;
    wait_halt(100, "alu");
    vectors++; if (wb_a3.size() != 7) begin miscompares++; $display("FAIL alu_wb_count: got %0d want 7", wb_a3.size()); end
    for (int i = 0; i < 7 && i < wb_a3.size(); i++) begin
      vectors++;
      if (wb_a3[i] !== ea[i] || wb_wd3[i] !== ew[i]) begin
        miscompares++; $display("FAIL alu_wb%0d: got a3=%0d wd3=%h want a3=%0d wd3=%h", i, wb_a3[i], wb_wd3[i], ea[i], ew[i]); end
    end
    vectors++; if (fetch_cyc.size() < 3 || fetch_cyc[1] - fetch_cyc[0] != 4 || fetch_cyc[2] - fetch_cyc[1] != 4) begin
      miscompares++; $display("FAIL alu_latency: got %0d,%0d want 4,4", fetch_cyc[1] - fetch_cyc[0], fetch_cyc[2] - fetch_cyc[1]); end
    vectors++; if (bus.retired !== 32'd7) begin miscompares++; $display("FAIL alu_retired: got %0d want 7", bus.retired); end
    vectors++; if (bus.illegal !== 1'b1 || bus.pc !== 32'h11C) begin
      miscompares++; $display("FAIL alu_end: illegal=%b pc=%h want 1/0000011c", bus.illegal, bus.pc); end
  endtask

  task automatic test_mem();
    do_reset();
    dmem_wait = 2;
    put(32'h100, enc_i(6'h08, 5'd0, 5'd2, 16'd10));
    put(32'h104, enc_i(6'h2b, 5'd0, 5'd2, 16'd8));
    put(32'h108, enc_i(6'h23, 5'd0, 5'd3, 16'd8));
    put(32'h10C, ILL);
    rst_n = 1'b1;
    wait_halt(100, "mem");
    vectors++; if (acc_a.size() != 2) begin miscompares++; $display("FAIL mem_acc_count: got %0d want 2", acc_a.size()); end
    vectors++; if (acc_a[0] !== 32'd8 || acc_wd[0] !== 32'd10 || acc_we[0] !== 1'b1 || acc_len[0] != 3) begin
      miscompares++; $display("FAIL mem_store: a=%h wd=%h we=%b len=%0d want 8/a/1/3", acc_a[0], acc_wd[0], acc_we[0], acc_len[0]); end
    vectors++; if (acc_a[1] !== 32'd8 || acc_we[1] !== 1'b0 || acc_len[1] != 3) begin
      miscompares++; $display("FAIL mem_load_req: a=%h we=%b len=%0d want 8/0/3", acc_a[1], acc_we[1], acc_len[1]); end
    vectors++; if (wb_a3.size() != 2 || wb_a3[1] !== 5'd3 || wb_wd3[1] !== 32'd10 || regs[3] !== 32'd10) begin
      miscompares++; $display("FAIL mem_load_wb: a3=%0d wd3=%h r3=%h want 3/a/a", wb_a3[1], wb_wd3[1], regs[3]); end
    vectors++; if (fetch_cyc.size() < 4 || fetch_cyc[2] - fetch_cyc[1] != 6 || fetch_cyc[3] - fetch_cyc[2] != 7) begin
      miscompares++; $display("FAIL mem_latency: sw=%0d lw=%0d want 6/7", fetch_cyc[2] - fetch_cyc[1], fetch_cyc[3] - fetch_cyc[2]); end
    vectors++; if (bus.retired !== 32'd3) begin miscompares++; $display("FAIL mem_retired: got %0d want 3", bus.retired); end
  endtask

  task automatic test_branch();
    do_reset();
    put(32'h100, enc_j(6'h02, 26'h4));
    put(32'h010, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    rst_n = 1'b1;
    wait_fetches(3, 40, "beq");
    vectors++; if (fetch_addr[1] !== 32'h10 || fetch_addr[2] !== 32'h10) begin
      miscompares++; $display("FAIL beq_target: got %h,%h want 10,10", fetch_addr[1], fetch_addr[2]); end
    vectors++; if (fetch_cyc[1] - fetch_cyc[0] != 3 || fetch_cyc[2] - fetch_cyc[1] != 3) begin
      miscompares++; $display("FAIL beq_latency: j=%0d beq=%0d want 3/3", fetch_cyc[1] - fetch_cyc[0], fetch_cyc[2] - fetch_cyc[1]); end
    vectors++; if (bus.retired !== 32'd2) begin miscompares++; $display("FAIL beq_retired: got %0d want 2", bus.retired); end

    do_reset();
    put(32'h100, enc_j(6'h02, 26'h4));
    put(32'h010, enc_i(6'h05, 5'd0, 5'd0, 16'hFFFF));
    put(32'h014, enc_j(6'h02, 26'h8));
    put(32'h020, enc_j(6'h03, 26'h10));
    put(32'h040, enc_r(5'd31, 5'd0, 5'd0, 6'h08));
    put(32'h024, ILL);
    rst_n = 1'b1;
    wait_halt(100, "jump");
    vectors++; if (fetch_addr.size() != 6 || fetch_addr[2] !== 32'h14 || fetch_cyc[2] - fetch_cyc[1] != 3) begin
      miscompares++; $display("FAIL bne_fall: n=%0d addr=%h lat=%0d want 6/14/3", fetch_addr.size(), fetch_addr[2], fetch_cyc[2] - fetch_cyc[1]); end
    vectors++; if (wb_a3.size() != 1 || wb_a3[0] !== 5'd31 || wb_wd3[0] !== 32'h24) begin
      miscompares++; $display("FAIL jal_link: a3=%0d wd3=%h want 31/24", wb_a3[0], wb_wd3[0]); end
    vectors++; if (fetch_addr[4] !== 32'h40 || fetch_cyc[4] - fetch_cyc[3] != 4) begin
      miscompares++; $display("FAIL jal_target: addr=%h lat=%0d want 40/4", fetch_addr[4], fetch_cyc[4] - fetch_cyc[3]); end
    vectors++; if (fetch_addr[5] !== 32'h24 || fetch_cyc[5] - fetch_cyc[4] != 3) begin
      miscompares++; $display("FAIL jr_target: addr=%h lat=%0d want 24/3", fetch_addr[5], fetch_cyc[5] - fetch_cyc[4]); end
    vectors++; if (bus.retired !== 32'd5 || bus.pc !== 32'h24) begin
      miscompares++; $display("FAIL jump_end: retired=%0d pc=%h want 5/24", bus.retired, bus.pc); end
  endtask

  task automatic test_timeout();
    do_reset();
    imem_stall = 1'b1;
    put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    rst_n = 1'b1;
    wait_halt(40, "itimeout");
    vectors++; if (bus.bus_error !== 1'b1 || bus.illegal !== 1'b0 || bus.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL itimeout_flags: bus_error=%b illegal=%b req=%b want 1/0/0", bus.bus_error, bus.illegal, bus.imem_req); end
    vectors++; if (iwait_cycles != 16 || bus.pc !== 32'h100) begin
      miscompares++; $display("FAIL itimeout_wait: waits=%0d pc=%h want 16/100", iwait_cycles, bus.pc); end
    imem_stall = 1'b0;
    repeat (5) @(negedge clk);
    vectors++; if (bus.halted !== 1'b1 || fetch_addr.size() != 0 || bus.retired !== 32'd0) begin
      miscompares++; $display("FAIL itimeout_sticky: halted=%b fetches=%0d retired=%0d want 1/0/0", bus.halted, fetch_addr.size(), bus.retired); end

    do_reset();
    dmem_stall = 1'b1;
    put(32'h100, enc_i(6'h23, 5'd0, 5'd3, 16'd8));
    rst_n = 1'b1;
    wait_halt(60, "dtimeout");
    vectors++; if (bus.bus_error !== 1'b1 || bus.dmem_req !== 1'b0 || bus.pc !== 32'h100 || wb_a3.size() != 0) begin
      miscompares++; $display("FAIL dtimeout: bus_error=%b req=%b pc=%h wb=%0d want 1/0/100/0", bus.bus_error, bus.dmem_req, bus.pc, wb_a3.size()); end
  endtask

  task automatic test_illegal();
    do_reset();
    put(32'h100, ILL);
    rst_n = 1'b1;
    wait_halt(20, "illegal");
    vectors++; if (bus.illegal !== 1'b1 || bus.bus_error !== 1'b0 || bus.pc !== 32'h100) begin
      miscompares++; $display("FAIL illegal_flags: illegal=%b bus_error=%b pc=%h want 1/0/100", bus.illegal, bus.bus_error, bus.pc); end
    vectors++; if (wb_a3.size() != 0 || acc_a.size() != 0 || bus.retired !== 32'd0) begin
      miscompares++; $display("FAIL illegal_side: wb=%0d acc=%0d retired=%0d want 0/0/0", wb_a3.size(), acc_a.size(), bus.retired); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.halted !== 1'b0 || bus.illegal !== 1'b0 || bus.bus_error !== 1'b0) begin
      miscompares++; $display("FAIL illegal_clear: halted=%b illegal=%b bus_error=%b want 0", bus.halted, bus.illegal, bus.bus_error); end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_stall = 1'b0;
    dmem_stall = 1'b0;
    dmem_wait = 0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_timeout();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
